// File: rtl/lvdc_mem_pkg.sv
// rtl/lvdc_mem_pkg.sv - shared types, address field positions and select decoder for the core-memory sequencer
package lvdc_mem_pkg;

    typedef enum logic [2:0] {
        sIdle,
        sSetup,
        sRead,
        sCapt,
        sWrite,
        sRec
    } memState_t;

    // High-decade X field is the split {addr[AX0_HI], addr[AX0_LO +: 2]}
    localparam int AX_LO  = 0;
    localparam int AY_LO  = 3;
    localparam int AX0_LO = 6;
    localparam int AY0_LO = 8;
    localparam int AX0_HI = 11;

    function automatic logic [7:0] onehot_n(input logic [2:0] sel);
        return ~(8'h01 << sel);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter that parks at zero and flags it
module phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] loadValue,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/memory_cycle_sequencer.sv
// rtl/memory_cycle_sequencer.sv - sequences one core-memory read/regenerate or read/write cycle
module memory_cycle_sequencer
    import lvdc_mem_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_READ  = 4,
    parameter int T_WRITE = 4,
    parameter int T_REC   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [11:0] addr,
    input  logic        syl,
    input  logic        wr,
    input  logic [13:0] sa,
    output logic        ack,
    output logic        done,
    output logic        busy,
    output logic [13:0] rd_data,
    output logic [7:0]  ax_n,
    output logic [7:0]  ay_n,
    output logic [7:0]  ax0_n,
    output logic [7:0]  ay0_n,
    output logic        syl0_n,
    output logic        syl1_n,
    output logic        rdm,
    output logic        rdm_n,
    output logic        sync,
    output logic        brov_a,
    output logic        brov_b,
    output logic        inhbs
);

    localparam int T_MAX_SR = (T_SETUP > T_READ) ? T_SETUP : T_READ;
    localparam int T_MAX_WR = (T_WRITE > T_REC) ? T_WRITE : T_REC;
    localparam int T_MAX    = (T_MAX_SR > T_MAX_WR) ? T_MAX_SR : T_MAX_WR;
    localparam int CW       = $clog2(T_MAX + 1);

    if (T_SETUP < 1 || T_READ < 1 || T_WRITE < 1 || T_REC < 1) begin : gBadTiming
        $error("memory_cycle_sequencer: every phase length must be at least 1 cycle");
    end

    memState_t      state, nextState;
    logic           timerLoad, timerZero;
    logic [CW-1:0]  timerLoadValue, timerCount;
    logic [11:0]    addrQ, addrN;
    logic           sylQ, sylN, wrQ, wrN;
    logic           accept, driving, lastRec;

    phase_timer #(.W(CW)) uTimer (
        .clk       (clk),
        .rst       (rst),
        .load      (timerLoad),
        .loadValue (timerLoadValue),
        .count     (timerCount),
        .zero      (timerZero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= sIdle;
        end else begin
            state <= nextState;
        end
    end

    // Each phase reloads the timer with length-1 on entry and leaves when it reaches zero
    always_comb begin
        nextState      = state;
        timerLoad      = 1'b0;
        timerLoadValue = '0;
        case (state)
            sIdle: if (req) begin
                nextState      = sSetup;
                timerLoad      = 1'b1;
                timerLoadValue = CW'(T_SETUP - 1);
            end
            sSetup: if (timerZero) begin
                nextState      = sRead;
                timerLoad      = 1'b1;
                timerLoadValue = CW'(T_READ - 1);
            end
            sRead: if (timerZero) begin
                nextState      = sCapt;
                timerLoad      = 1'b1;
            end
            sCapt: begin
                nextState      = sWrite;
                timerLoad      = 1'b1;
                timerLoadValue = CW'(T_WRITE - 1);
            end
            sWrite: if (timerZero) begin
                nextState      = sRec;
                timerLoad      = 1'b1;
                timerLoadValue = CW'(T_REC - 1);
            end
            sRec: if (timerZero) begin
                nextState      = sIdle;
            end
            default: nextState = sIdle;
        endcase
    end

    // Outputs are registered from the upcoming state, so they line up with the state itself
    always_comb begin
        accept  = (state == sIdle) && req;
        addrN   = accept ? addr : addrQ;
        sylN    = accept ? syl : sylQ;
        wrN     = accept ? wr : wrQ;
        driving = nextState inside {sSetup, sRead, sCapt, sWrite};
        lastRec = (nextState == sRec) &&
                  ((state == sRec) ? (timerCount == CW'(1)) : (T_REC == 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addrQ <= '0;
            sylQ  <= 1'b0;
            wrQ   <= 1'b0;
        end else if (accept) begin
            addrQ <= addr;
            sylQ  <= syl;
            wrQ   <= wr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack     <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            rd_data <= '0;
            ax_n    <= 8'hFF;
            ay_n    <= 8'hFF;
            ax0_n   <= 8'hFF;
            ay0_n   <= 8'hFF;
            syl0_n  <= 1'b1;
            syl1_n  <= 1'b1;
            rdm     <= 1'b0;
            rdm_n   <= 1'b1;
            sync    <= 1'b0;
            brov_a  <= 1'b0;
            brov_b  <= 1'b0;
            inhbs   <= 1'b1;
        end else begin
            ack    <= accept;
            done   <= lastRec;
            busy   <= (nextState != sIdle);
            ax_n   <= driving ? onehot_n(addrN[AX_LO +: 3]) : 8'hFF;
            ay_n   <= driving ? onehot_n(addrN[AY_LO +: 3]) : 8'hFF;
            ax0_n  <= driving ? onehot_n({addrN[AX0_HI], addrN[AX0_LO +: 2]}) : 8'hFF;
            ay0_n  <= driving ? onehot_n(addrN[AY0_LO +: 3]) : 8'hFF;
            syl0_n <= ~(driving && !sylN);
            syl1_n <= ~(driving && sylN);
            rdm    <= (nextState == sRead);
            rdm_n  <= (nextState != sRead);
            inhbs  <= (nextState != sRead);
            sync   <= ((nextState == sRead) && (state != sRead)) ||
                      ((nextState == sWrite) && (state != sWrite));
            brov_a <= (nextState == sWrite) && wrN;
            brov_b <= (nextState == sWrite) && !wrN;
            if (state == sCapt) begin
                rd_data <= sa;
            end
        end
    end

endmodule

// File: tb/tb_memory_cycle_sequencer.sv
// tb/tb_memory_cycle_sequencer.sv - self-checking bench for memory_cycle_sequencer
module tb_memory_cycle_sequencer;

    localparam int T_SETUP  = 2;
    localparam int T_READ   = 4;
    localparam int T_WRITE  = 4;
    localparam int T_REC    = 1;
    localparam int READ_AT  = T_SETUP;
    localparam int CAPT_AT  = T_SETUP + T_READ;
    localparam int WRITE_AT = CAPT_AT + 1;
    localparam int REC_AT   = WRITE_AT + T_WRITE;
    localparam int LAST_AT  = REC_AT + T_REC - 1;

    localparam logic [42:0] IDLE_VEC = {3'b000, 32'hFFFF_FFFF, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1};

    logic        clk = 1'b0;
    logic        rst, req, syl, wr;
    logic [11:0] addr;
    logic [13:0] sa;
    logic        ack, done, busy;
    logic [13:0] rd_data;
    logic [7:0]  ax_n, ay_n, ax0_n, ay0_n;
    logic        syl0_n, syl1_n, rdm, rdm_n, sync, brov_a, brov_b, inhbs;
    logic [42:0] outVec;

    int passCount  = 0;
    int totalCount = 0;

    logic [13:0] expRd;
    logic [31:0] selAtRead;
    logic [1:0]  sylAtRead;
    logic [13:0] rdAtDone;
    int          doneAt, busyCycles, brovACycles, brovBCycles, syncPulses;

    typedef struct {
        logic [11:0] a;
        logic        s;
        logic        w;
        logic [13:0] d;
        logic [31:0] sel;
    } vec_t;
    vec_t tbl[4];

    memory_cycle_sequencer #(
        .T_SETUP(T_SETUP), .T_READ(T_READ), .T_WRITE(T_WRITE), .T_REC(T_REC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .syl(syl), .wr(wr), .sa(sa),
        .ack(ack), .done(done), .busy(busy), .rd_data(rd_data),
        .ax_n(ax_n), .ay_n(ay_n), .ax0_n(ax0_n), .ay0_n(ay0_n),
        .syl0_n(syl0_n), .syl1_n(syl1_n), .rdm(rdm), .rdm_n(rdm_n), .sync(sync),
        .brov_a(brov_a), .brov_b(brov_b), .inhbs(inhbs)
    );

    always #5 clk = ~clk;

    assign outVec = {ack, done, busy, ax_n, ay_n, ax0_n, ay0_n, syl0_n, syl1_n,
                     rdm, rdm_n, sync, brov_a, brov_b, inhbs};

    // Expected drive pattern k cycles after the ack cycle, from the phase timeline
    function automatic logic [42:0] modelVec(input int k, input logic [11:0] a, input logic s, input logic w);
        logic        drive, rd, wp;
        logic [2:0]  hx;
        logic [31:0] sel;
        drive = (k < REC_AT);
        rd    = (k >= READ_AT) && (k < CAPT_AT);
        wp    = (k >= WRITE_AT) && (k < REC_AT);
        hx    = {a[11], a[7:6]};
        sel   = drive ? {~(8'h01 << a[2:0]), ~(8'h01 << a[5:3]), ~(8'h01 << hx), ~(8'h01 << a[10:8])}
                      : 32'hFFFF_FFFF;
        return {k == 0, k == LAST_AT, 1'b1, sel, drive ? s : 1'b1, drive ? ~s : 1'b1,
                rd, ~rd, (k == READ_AT) || (k == WRITE_AT), wp && w, wp && !w, ~rd};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic checkIdle(input string name);
        check({name, "_outputs"}, outVec, IDLE_VEC);
        check({name, "_rd_data"}, rd_data, expRd);
    endtask

    task automatic runCycle(input logic [11:0] a, input logic s, input logic w, input logic [13:0] d,
                            input bit keepReq, input int expWait);
        int waited;
        addr = a; syl = s; wr = w; req = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ack && waited < 20);
        check("ack_wait", waited, expWait);
        if (!ack) begin
            req = 1'b0;
            return;
        end
        doneAt = -1; busyCycles = 0; brovACycles = 0; brovBCycles = 0; syncPulses = 0;
        for (int k = 0; k <= LAST_AT; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("cycle%0d_outputs", k), outVec, modelVec(k, a, s, w));
            check($sformatf("cycle%0d_rd_data", k), rd_data, (k > CAPT_AT) ? d : expRd);
            if (k == READ_AT + 1) begin
                selAtRead = {ax_n, ay_n, ax0_n, ay0_n};
                sylAtRead = {syl0_n, syl1_n};
            end
            if (done) begin
                doneAt   = k;
                rdAtDone = rd_data;
            end
            busyCycles  += int'(busy);
            brovACycles += int'(brov_a);
            brovBCycles += int'(brov_b);
            syncPulses  += int'(sync);
            if (!keepReq) req = (k < LAST_AT) ? 1'($urandom_range(0, 1)) : 1'b0;
            sa = (k == CAPT_AT) ? d : 14'($urandom);
        end
        expRd = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        bit doneSeen;

        tbl[0] = '{12'o0000, 1'b0, 1'b0, 14'h1ABC, 32'hFEFE_FEFE};
        tbl[1] = '{12'o7777, 1'b1, 1'b1, 14'h0F0F, 32'h7F7F_7F7F};
        tbl[2] = '{12'o4321, 1'b0, 1'b1, 14'h2345, 32'hFDFB_7FFE};
        tbl[3] = '{12'o1234, 1'b1, 1'b0, 14'h3FFF, 32'hEFF7_FBFB};

        rst = 1'b1; req = 1'b0; addr = '0; syl = 1'b0; wr = 1'b0; sa = '0;
        expRd = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outVec, IDLE_VEC);
        check("reset_rd_data", rd_data, 14'h0);
        rst = 1'b0;
        @(negedge clk);
        checkIdle("post_reset");

        // Reset in the second READ cycle aborts the cycle with no done
        addr = 12'o2525; syl = 1'b1; wr = 1'b1; req = 1'b1;
        @(negedge clk);
        check("abort_ack", ack, 1'b1);
        req = 1'b0;
        repeat (READ_AT + 1) @(negedge clk);
        check("abort_in_read", {rdm, rdm_n, inhbs}, 3'b100);
        rst = 1'b1; sa = 14'h2AAA;
        @(negedge clk);
        check("abort_outputs", outVec, IDLE_VEC);
        check("abort_rd_data", rd_data, expRd);
        rst = 1'b0;
        doneSeen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) doneSeen = 1'b1;
        end
        check("abort_no_done", doneSeen, 1'b0);
        checkIdle("after_abort");

        for (int i = 0; i < 4; i++) begin
            runCycle(tbl[i].a, tbl[i].s, tbl[i].w, tbl[i].d, 1'b0, 1);
            check($sformatf("t%0d_selects", i), selAtRead, tbl[i].sel);
            check($sformatf("t%0d_syl_lines", i), sylAtRead, {tbl[i].s, ~tbl[i].s});
            check($sformatf("t%0d_done_offset", i), doneAt, 11);
            check($sformatf("t%0d_rd_at_done", i), rdAtDone, tbl[i].d);
            check($sformatf("t%0d_busy_cycles", i), busyCycles, 12);
            check($sformatf("t%0d_brov_a_cycles", i), brovACycles, tbl[i].w ? 4 : 0);
            check($sformatf("t%0d_brov_b_cycles", i), brovBCycles, tbl[i].w ? 0 : 4);
            check($sformatf("t%0d_sync_pulses", i), syncPulses, 2);
            @(negedge clk);
            checkIdle($sformatf("t%0d_idle", i));
        end

        // req held high: one IDLE cycle between done and the next ack
        runCycle(12'o0123, 1'b0, 1'b0, 14'h0155, 1'b1, 1);
        runCycle(12'o6543, 1'b1, 1'b1, 14'h2AA2, 1'b1, 2);
        runCycle(12'o3070, 1'b0, 1'b1, 14'h1001, 1'b1, 2);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkIdle("b2b_end");

        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                checkIdle("gap");
            end
            runCycle(12'($urandom), 1'($urandom), 1'($urandom), 14'($urandom), 1'b0, 1);
            @(negedge clk);
            checkIdle("rand_idle");
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
